inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, 4, number of encoded-word FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_W, 10, width of the word address counter.
REQ-003 The block SHALL have port clk input 1, sole clock, rising edge.
REQ-004 The block SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid input 1, field tuple present.
REQ-006 The block SHALL have port in_ready output 1, encoder can accept a tuple.
REQ-007 The block SHALL have port fmt input 2, 0=R, 1=I, 2=J, 3=reserved.
REQ-008 The block SHALL have ports opcode input 6, rs input 5, rt input 5, rd input 5, shamt input 5, funct input 6, imm16 input 16, imm26 input 26, instruction fields.
REQ-009 The block SHALL have port out_valid output 1, encoded word available.
REQ-010 The block SHALL have port out_ready input 1, sink accepts word.
REQ-011 The block SHALL have port out_inst output 32, encoded instruction word.
REQ-012 The block SHALL have port out_addr output ADDR_W, word address for out_inst.
REQ-013 The block SHALL have ports addr_load input 1 and addr_base input ADDR_W, synchronous address counter load.
REQ-014 The block SHALL have port err output 1, sticky reserved-format flag.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-016 Encoding SHALL be: R = {opcode,rs,rt,rd,shamt,funct}; I = {opcode,rs,rt,imm16}; J = {opcode,imm26}; unused fields SHALL be ignored.
REQ-017 An accepted word SHALL be written into the FIFO at the transfer edge; out_valid SHALL rise no earlier than the next cycle (latency 1, no combinational bypass).
REQ-018 in_ready SHALL equal "FIFO not full", independent of in_valid and out_ready; a pop on a full FIFO SHALL NOT enable a same-cycle push.
REQ-019 out_valid SHALL equal "FIFO not empty"; out_inst SHALL be the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 out_addr SHALL equal the address counter; each output transfer SHALL increment it by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-022 addr_load=1 SHALL set the counter to addr_base at the edge, overriding any same-cycle increment; a word transferred that cycle SHALL carry the pre-load address.
REQ-023 FIFO contents SHALL be unaffected by addr_load.

Reset
REQ-024 rst_n=0 SHALL immediately empty the FIFO, clear the address counter to 0, and clear err.
REQ-025 During reset in_ready, out_valid, out_inst, out_addr and err SHALL be 0; in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-026 Reset mid-operation SHALL discard all buffered words without emitting them.

Configuration
REQ-027 With ENCODER_FMT_CHECK_EN defined, a transfer with fmt=3 SHALL still complete (in_ready honoured), SHALL NOT be written to the FIFO, and SHALL set err=1 until reset.
REQ-028 Without ENCODER_FMT_CHECK_EN, fmt=3 SHALL be encoded as J and err SHALL be tied to 0.

Verification
REQ-029 R-format opcode=0,rs=1,rt=2,rd=3,shamt=0,funct=0x20, out_ready=1 -> next cycle out_inst=0x00221820, out_addr=0, then out_addr=1.
REQ-030 I-format opcode=0x08,rs=1,rt=2,imm16=0xFFFF and J-format opcode=0x02,imm26=0x0000100 -> out_inst 0x2022FFFF then 0x08000100, in order.
REQ-031 out_ready=0, push 5 words with DEPTH=4 -> in_ready=0 after the 4th; release out_ready -> exactly 4 words out, then the 5th accepted.
REQ-032 addr_load=1 with addr_base=0x3FF, then 2 transfers -> out_addr 0x3FF then 0x000 (wrap).
REQ-033 With ENCODER_FMT_CHECK_EN: fmt=3 tuple then valid R tuple -> only the R word emitted, err=1; rst_n pulse low mid-stream -> err=0, out_valid=0, out_addr=0.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Handshake and field bus between an instruction-tuple source, the encoder and a word sink.
// The slave modport is the encoder's view; the master modport is the environment's view.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/inst_encoder.sv
// MIPS-style R/I/J instruction encoder with a DEPTH-entry output FIFO and word address counter.
// Optional ENCODER_FMT_CHECK_EN drops reserved-format tuples and raises a sticky err flag.
module inst_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_encoder_if.slave     bus,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [ADDR_W-1:0] addr_r;
    logic              ready_en_r;

    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              fmt_ok_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       word_s;

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm16,
        input logic [25:0] imm26
    );
        logic [31:0] w;
        case (fmt)
            2'd0:    w = {opcode, rs, rt, rd, shamt, funct};
            2'd1:    w = {opcode, rs, rt, imm16};
            2'd2:    w = {opcode, imm26};
            default: w = {opcode, imm26};
        endcase
        return w;
    endfunction

    assign full_s   = (count_r == FULL_CNT);
    assign empty_s  = (count_r == '0);
    // in_ready looks only at the registered full flag, so a pop never frees a slot in the same cycle
    assign accept_s = bus.in_valid & ready_en_r & ~full_s;
    assign push_s   = accept_s & fmt_ok_s;
    assign pop_s    = ~empty_s & bus.out_ready;
    assign word_s   = encode(bus.fmt, bus.opcode, bus.rs, bus.rt, bus.rd,
                             bus.shamt, bus.funct, bus.imm16, bus.imm26);

    assign bus.in_ready  = ready_en_r & ~full_s;
    assign bus.out_valid = ~empty_s;
    assign bus.out_inst  = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r];
    assign bus.out_addr  = addr_r;

`ifdef ENCODER_FMT_CHECK_EN
    logic err_r;

    assign fmt_ok_s = (bus.fmt != 2'd3);
    assign err      = err_r;

    // Sticky flag for reserved-format tuples, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept_s && !fmt_ok_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign fmt_ok_s = 1'b1;
    assign err      = 1'b0;
`endif

    // Storage array; validity is tracked by the pointers, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word address counter; a load wins over the increment of a same-cycle transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
        end else if (addr_load) begin
            addr_r <= addr_base;
        end else if (pop_s) begin
            addr_r <= addr_r + ADDR_W'(1);
        end else begin
            addr_r <= addr_r;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table plus hand sequences, with an output scoreboard.
module tb_inst_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_base = '0;
    logic              err;

    int                total = 0;
    int                bad = 0;
    bit                mon_en = 1'b0;
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] model_addr = '0;
    vec_t              tbl[6];
    vec_t              v3;
    vec_t              rv;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .addr_load(addr_load),
        .addr_base(addr_base),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                                 input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                 input logic [5:0] fn, input logic [15:0] i16,
                                 input logic [25:0] i26, input logic [31:0] e);
        vec_t v;
        v.fmt = f; v.opcode = op; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
        v.funct = fn; v.imm16 = i16; v.imm26 = i26; v.exp = e;
        return v;
    endfunction

    function automatic logic [31:0] enc(input vec_t v);
        case (v.fmt)
            2'd0:    return {v.opcode, v.rs, v.rt, v.rd, v.shamt, v.funct};
            2'd1:    return {v.opcode, v.rs, v.rt, v.imm16};
            default: return {v.opcode, v.imm26};
        endcase
    endfunction

    // Drive one tuple; the expectation is queued on the cycle the handshake is seen
    task automatic send(input vec_t v, input bit store);
        bit done = 1'b0;
        bus.fmt = v.fmt; bus.opcode = v.opcode; bus.rs = v.rs; bus.rt = v.rt;
        bus.rd = v.rd; bus.shamt = v.shamt; bus.funct = v.funct;
        bus.imm16 = v.imm16; bus.imm26 = v.imm26; bus.in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (store) exp_q.push_back(v.exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        @(posedge clk); #1;
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
        end
    endtask

    // Scoreboard and address model, evaluated half a cycle before each active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) chk("out_addr", 32'(bus.out_addr), 32'(model_addr));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %h, required no word", bus.out_inst);
                end else begin
                    chk("out_inst", bus.out_inst, exp_q.pop_front());
                end
            end
            if (addr_load) model_addr = addr_base;
            else if (bus.out_valid && bus.out_ready) model_addr = model_addr + 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mkv(2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hABCD, 26'h1555555, 32'h00221820);
        tbl[1] = mkv(2'd1, 6'h08, 5'd1,  5'd2,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h2022FFFF);
        tbl[2] = mkv(2'd2, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h0000100, 32'h08000100);
        tbl[3] = mkv(2'd0, 6'h00, 5'h1F, 5'h00, 5'h1F, 5'h1F, 6'h3F, 16'h5A5A, 26'h2AAAAAA, 32'h03E0FFFF);
        tbl[4] = mkv(2'd1, 6'h3F, 5'h00, 5'h00, 5'h15, 5'h0A, 6'h2A, 16'h1234, 26'h3FFFFFF, 32'hFC001234);
        tbl[5] = mkv(2'd2, 6'h3F, 5'h00, 5'h00, 5'h00, 5'h00, 6'h00, 16'h0000, 26'h3FFFFFF, 32'hFFFFFFFF);
        v3     = mkv(2'd3, 6'h02, 5'h0F, 5'h0F, 5'h0F, 5'h0F, 6'h0F, 16'h0F0F, 26'h0000100, 32'h08000100);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.fmt = 2'd0; bus.opcode = 6'd0; bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0;
        bus.shamt = 5'd0; bus.funct = 6'd0; bus.imm16 = 16'd0; bus.imm26 = 26'd0;

        // Reset state and in_ready rising on the first edge after release
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #21 rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 32'(bus.in_ready), 32'd1);

        // First R word: one-cycle latency, address 0 then 1
        mon_en = 1'b1; bus.out_ready = 1'b1;
        chk("no_bypass", 32'(bus.out_valid), 32'd0);
        send(tbl[0], 1'b1);
        chk("latency_valid", 32'(bus.out_valid), 32'd1);
        chk("latency_inst", bus.out_inst, 32'h00221820);
        wait_drain();
        chk("addr_after_one", 32'(bus.out_addr), 32'd1);

        // Table vectors back to back, then random tuples under random backpressure
        for (int i = 1; i < 6; i++) send(tbl[i], 1'b1);
        wait_drain();
        for (int i = 0; i < 8; i++) begin
            rv = mkv(2'($urandom_range(0, 2)), 6'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), 32'd0);
            rv.exp = enc(rv);
            bus.out_ready = 1'($urandom_range(0, 1));
            send(rv, 1'b1);
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Fill to DEPTH with the sink stalled, then a fifth word waits for space
        bus.out_ready = 1'b0;
        for (int i = 1; i < 5; i++) send(tbl[i], 1'b1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(tbl[5], 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_head", bus.out_inst, tbl[1].exp);
                bus.out_ready = 1'b1;
                @(negedge clk);
                chk("pop_on_full_no_push", 32'(bus.in_ready), 32'd0);
            end
        join
        wait_drain();

        // Address load to the top, then wrap
        addr_load = 1'b1; addr_base = 10'h3FF;
        @(posedge clk); #1;
        addr_load = 1'b0;
        chk("addr_loaded", 32'(bus.out_addr), 32'h3FF);
        send(tbl[1], 1'b1);
        send(tbl[2], 1'b1);
        wait_drain();
        chk("addr_wrapped", 32'(bus.out_addr), 32'd1);

        // Load in the same cycle as a transfer: word keeps old address, FIFO untouched
        bus.out_ready = 1'b0;
        send(tbl[3], 1'b1);
        send(tbl[4], 1'b1);
        addr_load = 1'b1; addr_base = 10'h155; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        addr_load = 1'b0;
        chk("load_vs_pop", 32'(bus.out_addr), 32'h155);
        chk("load_keeps_fifo", bus.out_inst, tbl[4].exp);
        wait_drain();
        chk("addr_after_load", 32'(bus.out_addr), 32'h156);

        // Reserved format
`ifdef ENCODER_FMT_CHECK_EN
        send(v3, 1'b0);
        send(tbl[0], 1'b1);
        wait_drain();
        chk("err_sticky", 32'(err), 32'd1);
`else
        send(v3, 1'b1);
        wait_drain();
        chk("err_tied", 32'(err), 32'd0);
`endif

        // Reset mid-stream discards buffered words
        bus.out_ready = 1'b0;
        send(tbl[1], 1'b1);
        send(tbl[2], 1'b1);
        mon_en = 1'b0; rst_n = 1'b0;
        exp_q.delete(); model_addr = '0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);
        mon_en = 1'b1; bus.out_ready = 1'b1;
        send(tbl[0], 1'b1);
        wait_drain();
        chk("post_rst_addr", 32'(bus.out_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
